fb_triple_buffer_ctrl: RTL and testbench
========================================

Name: fb_triple_buffer_ctrl

Overview:
Triple-buffer scheduler for the shared frame buffer RAM, which is sized for three frame banks. Sits between the camera controller's write stream and the VGA controller's read stream. Steers camera writes into a free bank and VGA reads into the display bank. Flips banks only at frame boundaries, so the display never tears and the camera never stalls.

Parameters:
ADDR_W, 19, per-frame pixel address width from camera/VGA controllers
DATA_W, 12, pixel width (RGB444)
CNT_W, 16, width of status counters

Ports:
clk_i  in  1  system clock; single clock domain
rst_i  in  1  synchronous, active-high reset
cam_sof_i  in  1  one-cycle pulse, camera frame start
cam_eof_i  in  1  one-cycle pulse, camera frame complete
cam_wr_i  in  1  camera pixel write strobe
cam_addr_i  in  ADDR_W  camera pixel address within frame
cam_data_i  in  DATA_W  camera pixel
vga_sof_i  in  1  one-cycle pulse at VGA vertical blank start
vga_addr_i  in  ADDR_W  VGA pixel address within frame
freeze_i  in  1  level; 1 = hold current display bank
fb_wr_o  out  1  frame buffer write enable
fb_wr_addr_o  out  ADDR_W+2  {wr bank, cam_addr}
fb_wr_data_o  out  DATA_W  write data
fb_rd_addr_o  out  ADDR_W+2  {disp bank, vga_addr}
disp_bank_o  out  2  current display bank
frame_ready_o  out  1  completed frame waiting for flip
flip_cnt_o  out  CNT_W  number of display flips, saturating
drop_cnt_o  out  CNT_W  number of completed frames overwritten before display, saturating

Behaviour:
- Internal state: disp_q, ready_q, wr_q (bank indices 0..2, always a permutation of the three), ready_vld_q, capturing_q.
- Reset values:
  - disp=0, wr=1, ready=2, ready_vld=0, capturing=0.
  - All outputs 0, except fb_rd_addr_o = {2'd0, 0}.
  - Counters 0.
- cam_sof_i: capturing<=1. If already capturing, the partial frame is abandoned and capture restarts in the same wr bank. No counter changes.
- Writes: fb_wr_o <= cam_wr_i & capturing_q. fb_wr_addr_o <= {wr_q, cam_addr_i}. fb_wr_data_o <= cam_data_i.
  - Latency is 1 cycle, all registered.
  - Writes outside SOF..EOF are suppressed.
- cam_eof_i with capturing_q=1:
  - Swap wr and ready; ready_vld<=1; capturing<=0.
  - If ready_vld was already 1, drop_cnt++ (the older frame is discarded).
- cam_eof_i with capturing_q=0: ignored.
- cam_sof_i and cam_eof_i in the same cycle: EOF is processed first, then SOF sets capturing=1 on the new wr bank.
- vga_sof_i with ready_vld=1 and freeze_i=0: swap disp and ready; ready_vld<=0; flip_cnt++.
  - Otherwise (no ready frame, or freeze_i=1): no change; the current frame is repeated.
  - freeze_i never blocks camera capture. Ready frames keep being replaced and drop_cnt counts those replacements.
- cam_eof_i and vga_sof_i in the same cycle:
  - Resolved as EOF then flip, in one update.
  - Result: new disp = old wr, new ready = old disp, new wr = old ready, ready_vld=0.
  - drop_cnt++ if ready_vld was 1; flip_cnt++ unless frozen.
  - If frozen: only the EOF swap is applied.
- Reads: fb_rd_addr_o <= {disp_q, vga_addr_i}, 1-cycle latency. disp_bank_o = disp_q. The display bank changes only on a vga_sof_i cycle.
- frame_ready_o = ready_vld_q.
- Counters: saturate at all-ones; no wrap.
- Reset mid-frame: everything returns to reset values the next cycle. In-flight writes are dropped (fb_wr_o=0).

Decomposition:
- Package fb_pkg:
  - bank_t (logic [1:0]), NUM_BANKS=3.
  - Reset constants DISP_RST=0, WR_RST=1, READY_RST=2.
  - bank_sel_t struct {disp, ready, wr} plus ready_vld, used for the next-state function.
- Sub-module sat_counter (parameter W; inputs inc_i, clk_i, rst_i; output cnt_o), instantiated twice for flip_cnt and drop_cnt.

Test Plan:
1. Reset, then SOF, 4 writes addr 0..3, EOF, then vga_sof -> fb_wr_addr_o bank field=1 on all writes; after EOF frame_ready_o=1; after vga_sof disp_bank_o=1, flip_cnt_o=1, frame_ready_o=0.
2. Writes with cam_wr_i=1 before any SOF -> fb_wr_o stays 0; after SOF, first write appears exactly 1 cycle later with data unchanged.
3. Two complete camera frames with no vga_sof between -> drop_cnt_o=1, frame_ready_o=1; next vga_sof -> disp_bank_o = bank written by the second frame; the three indices remain a permutation at every cycle.
4. cam_eof_i and vga_sof_i in the same cycle from reset state after one capture into bank 1 -> disp=1, ready=0, wr=2, frame_ready_o=0, flip_cnt_o=1.
5. freeze_i=1 across 3 captured frames and 3 vga_sof pulses -> disp_bank_o stays 0, flip_cnt_o=0, drop_cnt_o=2; release freeze, next vga_sof flips to the latest frame.
6. Assert rst_i mid-capture while writes are active -> next cycle fb_wr_o=0, disp_bank_o=0, counters 0, frame_ready_o=0; post-reset SOF writes to bank 1.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the triple-buffer frame scheduler.
// Holds the bank-rotation function, the single place where bank indices are permuted.
package fb_pkg;

    typedef logic [1:0] bank_t;

    localparam int    NUM_BANKS = 3;
    localparam bank_t DISP_RST  = 2'd0;
    localparam bank_t WR_RST    = 2'd1;
    localparam bank_t READY_RST = 2'd2;

    typedef struct packed {
        bank_t disp;
        bank_t ready;
        bank_t wr;
        logic  ready_vld;
    } bank_sel_t;

    localparam bank_sel_t SEL_RST = '{disp: DISP_RST, ready: READY_RST, wr: WR_RST, ready_vld: 1'b0};

    // The EOF swap is applied before the flip, so a same-cycle EOF+flip shows the new frame.
    function automatic bank_sel_t bank_next(input bank_sel_t cur, input logic eof, input logic flip_req);
        bank_sel_t s;
        s = cur;
        if (eof) begin
            s.wr        = cur.ready;
            s.ready     = cur.wr;
            s.ready_vld = 1'b1;
        end
        if (flip_req && s.ready_vld) begin
            s.disp      = s.ready;
            s.ready     = cur.disp;
            s.ready_vld = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/fb_triple_buffer_ctrl_sat_counter.sv
// Saturating event counter: increments on inc_i and holds at all-ones.
// Used for the display flip and dropped-frame statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fb_triple_buffer_ctrl.sv
// Triple-buffer scheduler: camera writes go to a free bank and VGA reads the display bank.
// Banks rotate only on camera EOF and VGA SOF, so the display never tears.
module fb_triple_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cam_sof_i,
    input  logic              cam_eof_i,
    input  logic              cam_wr_i,
    input  logic [ADDR_W-1:0] cam_addr_i,
    input  logic [DATA_W-1:0] cam_data_i,
    input  logic              vga_sof_i,
    input  logic [ADDR_W-1:0] vga_addr_i,
    input  logic              freeze_i,
    output logic              fb_wr_o,
    output logic [ADDR_W+1:0] fb_wr_addr_o,
    output logic [DATA_W-1:0] fb_wr_data_o,
    output logic [ADDR_W+1:0] fb_rd_addr_o,
    output logic [1:0]        disp_bank_o,
    output logic              frame_ready_o,
    output logic [CNT_W-1:0]  flip_cnt_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    bank_sel_t         sel_q, sel_d;
    logic              capturing_q, capturing_d;
    logic              eof_acc, flip_req, flip_inc, drop_inc;
    logic              fb_wr_q;
    logic [ADDR_W+1:0] fb_wr_addr_q;
    logic [DATA_W-1:0] fb_wr_data_q;
    logic [ADDR_W+1:0] fb_rd_addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q        <= SEL_RST;
            capturing_q  <= 1'b0;
            fb_wr_q      <= 1'b0;
            fb_wr_addr_q <= '0;
            fb_wr_data_q <= '0;
            fb_rd_addr_q <= '0;
        end else begin
            sel_q        <= sel_d;
            capturing_q  <= capturing_d;
            fb_wr_q      <= cam_wr_i & capturing_q;
            fb_wr_addr_q <= {sel_q.wr, cam_addr_i};
            fb_wr_data_q <= cam_data_i;
            fb_rd_addr_q <= {sel_q.disp, vga_addr_i};
        end
    end

    // A stray EOF outside a capture is ignored; SOF wins over EOF so capture restarts on the new bank.
    always_comb begin
        eof_acc  = cam_eof_i & capturing_q;
        flip_req = vga_sof_i & ~freeze_i;
        sel_d    = bank_next(sel_q, eof_acc, flip_req);
        flip_inc = flip_req & (sel_q.ready_vld | eof_acc);
        drop_inc = eof_acc & sel_q.ready_vld;
        capturing_d = capturing_q;
        if (cam_sof_i) begin
            capturing_d = 1'b1;
        end else if (eof_acc) begin
            capturing_d = 1'b0;
        end
    end

    always_comb begin
        fb_wr_o       = fb_wr_q;
        fb_wr_addr_o  = fb_wr_addr_q;
        fb_wr_data_o  = fb_wr_data_q;
        fb_rd_addr_o  = fb_rd_addr_q;
        disp_bank_o   = sel_q.disp;
        frame_ready_o = sel_q.ready_vld;
    end

    sat_counter #(.W(CNT_W)) u_flip_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flip_inc),
        .cnt_o (flip_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (drop_inc),
        .cnt_o (drop_cnt_o)
    );

endmodule

// File: tb/tb_fb_triple_buffer_ctrl.sv
// Bench for fb_triple_buffer_ctrl: per-scenario tasks with inline checks plus a
// write scoreboard that matches every frame buffer write against an expected queue.
module tb_fb_triple_buffer_ctrl;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 12;
    localparam int CNT_W  = 16;
    localparam int WR_W   = ADDR_W + 2 + DATA_W;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              cam_sof_i = 1'b0;
    logic              cam_eof_i = 1'b0;
    logic              cam_wr_i = 1'b0;
    logic [ADDR_W-1:0] cam_addr_i = '0;
    logic [DATA_W-1:0] cam_data_i = '0;
    logic              vga_sof_i = 1'b0;
    logic [ADDR_W-1:0] vga_addr_i = '0;
    logic              freeze_i = 1'b0;
    logic              fb_wr_o;
    logic [ADDR_W+1:0] fb_wr_addr_o;
    logic [DATA_W-1:0] fb_wr_data_o;
    logic [ADDR_W+1:0] fb_rd_addr_o;
    logic [1:0]        disp_bank_o;
    logic              frame_ready_o;
    logic [CNT_W-1:0]  flip_cnt_o;
    logic [CNT_W-1:0]  drop_cnt_o;

    int tests_run = 0;
    int tests_failed = 0;
    logic [WR_W-1:0] exp_q[$];

    fb_triple_buffer_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cam_sof_i     (cam_sof_i),
        .cam_eof_i     (cam_eof_i),
        .cam_wr_i      (cam_wr_i),
        .cam_addr_i    (cam_addr_i),
        .cam_data_i    (cam_data_i),
        .vga_sof_i     (vga_sof_i),
        .vga_addr_i    (vga_addr_i),
        .freeze_i      (freeze_i),
        .fb_wr_o       (fb_wr_o),
        .fb_wr_addr_o  (fb_wr_addr_o),
        .fb_wr_data_o  (fb_wr_data_o),
        .fb_rd_addr_o  (fb_rd_addr_o),
        .disp_bank_o   (disp_bank_o),
        .frame_ready_o (frame_ready_o),
        .flip_cnt_o    (flip_cnt_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Write scoreboard: every observed write must match the oldest expected write
    always @(negedge clk) begin
        if (fb_wr_o === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, expected no write", fb_wr_addr_o, fb_wr_data_o);
            end else begin
                logic [WR_W-1:0] exp_w;
                exp_w = exp_q.pop_front();
                if ({fb_wr_addr_o, fb_wr_data_o} !== exp_w) begin
                    tests_failed++;
                    $display("FAIL wr_match: got %h, expected %h", {fb_wr_addr_o, fb_wr_data_o}, exp_w);
                end
            end
        end
    end

    // Driver tasks: inputs change on the falling edge, DUT samples on the rising edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cam_sof_i = 1'b0; cam_eof_i = 1'b0; cam_wr_i = 1'b0;
        vga_sof_i = 1'b0; freeze_i = 1'b0; vga_addr_i = '0;
        step();
        step();
        rst_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_sof();
        cam_sof_i = 1'b1;
        step();
        cam_sof_i = 1'b0;
    endtask

    task automatic pulse_eof();
        cam_eof_i = 1'b1;
        step();
        cam_eof_i = 1'b0;
    endtask

    task automatic pulse_vsof();
        vga_sof_i = 1'b1;
        step();
        vga_sof_i = 1'b0;
    endtask

    task automatic cam_writes(input logic [1:0] bank, input int n, input logic seq_addr);
        for (int i = 0; i < n; i++) begin
            cam_wr_i   = 1'b1;
            cam_addr_i = seq_addr ? ADDR_W'(i) : ADDR_W'($urandom_range(0, 307199));
            cam_data_i = DATA_W'($urandom_range(0, 4095));
            exp_q.push_back({bank, cam_addr_i, cam_data_i});
            step();
        end
        cam_wr_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({fb_wr_o, fb_wr_addr_o, fb_wr_data_o, fb_rd_addr_o, disp_bank_o, frame_ready_o, flip_cnt_o, drop_cnt_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got wr=%b waddr=%h rdaddr=%h disp=%0d rdy=%b flip=%0d drop=%0d, expected all 0",
                     fb_wr_o, fb_wr_addr_o, fb_rd_addr_o, disp_bank_o, frame_ready_o, flip_cnt_o, drop_cnt_o);
        end
    endtask

    task automatic test_basic_frame();
        do_reset();
        pulse_sof();
        cam_writes(2'd1, 4, 1'b1);
        pulse_eof();
        tests_run++;
        if (frame_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_ready: got %b, expected 1", frame_ready_o);
        end
        vga_addr_i = ADDR_W'(5);
        pulse_vsof();
        tests_run++;
        if (disp_bank_o !== 2'd1 || flip_cnt_o !== 16'd1 || frame_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_flip: got disp=%0d flip=%0d rdy=%b, expected 1 1 0", disp_bank_o, flip_cnt_o, frame_ready_o);
        end
        step();
        tests_run++;
        if (fb_rd_addr_o !== {2'd1, ADDR_W'(5)}) begin
            tests_failed++;
            $display("FAIL basic_rdaddr: got %h, expected %h", fb_rd_addr_o, {2'd1, ADDR_W'(5)});
        end
    endtask

    task automatic test_write_gating();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cam_wr_i = 1'b1;
            cam_addr_i = ADDR_W'(i);
            step();
            tests_run++;
            if (fb_wr_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL gate_pre_sof: got fb_wr=%b, expected 0", fb_wr_o);
            end
        end
        cam_sof_i = 1'b1;
        step();
        cam_sof_i = 1'b0;
        a = ADDR_W'($urandom_range(0, 307199));
        d = DATA_W'($urandom_range(0, 4095));
        cam_addr_i = a;
        cam_data_i = d;
        exp_q.push_back({2'd1, a, d});
        step();
        cam_wr_i = 1'b0;
        tests_run++;
        if (fb_wr_o !== 1'b1 || fb_wr_data_o !== d || fb_wr_addr_o !== {2'd1, a}) begin
            tests_failed++;
            $display("FAIL gate_latency: got wr=%b addr=%h data=%h, expected 1 %h %h", fb_wr_o, fb_wr_addr_o, fb_wr_data_o, {2'd1, a}, d);
        end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse_sof();
        cam_writes(2'd1, 3, 1'b0);
        pulse_eof();
        pulse_sof();
        cam_writes(2'd2, 3, 1'b0);
        pulse_eof();
        tests_run++;
        if (drop_cnt_o !== 16'd1 || frame_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_drop: got drop=%0d rdy=%b, expected 1 1", drop_cnt_o, frame_ready_o);
        end
        pulse_vsof();
        tests_run++;
        if (disp_bank_o !== 2'd2 || flip_cnt_o !== 16'd1) begin
            tests_failed++;
            $display("FAIL b2b_flip: got disp=%0d flip=%0d, expected 2 1", disp_bank_o, flip_cnt_o);
        end
        // Remaining free bank is 1
        pulse_sof();
        cam_writes(2'd1, 2, 1'b0);
        step();
    endtask

    task automatic test_eof_flip_same_cycle();
        do_reset();
        pulse_sof();
        cam_writes(2'd1, 3, 1'b0);
        cam_eof_i = 1'b1;
        vga_sof_i = 1'b1;
        step();
        cam_eof_i = 1'b0;
        vga_sof_i = 1'b0;
        tests_run++;
        if (disp_bank_o !== 2'd1 || frame_ready_o !== 1'b0 || flip_cnt_o !== 16'd1 || drop_cnt_o !== 16'd0) begin
            tests_failed++;
            $display("FAIL combo_state: got disp=%0d rdy=%b flip=%0d drop=%0d, expected 1 0 1 0",
                     disp_bank_o, frame_ready_o, flip_cnt_o, drop_cnt_o);
        end
        // wr must be 2, then ready (0) becomes the next wr bank
        pulse_sof();
        cam_writes(2'd2, 2, 1'b0);
        pulse_eof();
        pulse_sof();
        cam_writes(2'd0, 2, 1'b0);
        step();
    endtask

    task automatic test_freeze();
        do_reset();
        freeze_i = 1'b1;
        for (int f = 0; f < 3; f++) begin
            pulse_sof();
            cam_writes((f == 1) ? 2'd2 : 2'd1, 2, 1'b0);
            pulse_eof();
            pulse_vsof();
            tests_run++;
            if (disp_bank_o !== 2'd0 || flip_cnt_o !== 16'd0) begin
                tests_failed++;
                $display("FAIL freeze_hold: got disp=%0d flip=%0d, expected 0 0", disp_bank_o, flip_cnt_o);
            end
        end
        tests_run++;
        if (drop_cnt_o !== 16'd2 || frame_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL freeze_drop: got drop=%0d rdy=%b, expected 2 1", drop_cnt_o, frame_ready_o);
        end
        freeze_i = 1'b0;
        pulse_vsof();
        tests_run++;
        if (disp_bank_o !== 2'd1 || flip_cnt_o !== 16'd1 || frame_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL freeze_release: got disp=%0d flip=%0d rdy=%b, expected 1 1 0", disp_bank_o, flip_cnt_o, frame_ready_o);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        pulse_sof();
        cam_writes(2'd1, 2, 1'b0);
        pulse_eof();
        pulse_vsof();
        pulse_sof();
        cam_writes(2'd2, 3, 1'b0);
        // Reset lands while a write is being presented; that write must be dropped
        cam_wr_i = 1'b1;
        vga_addr_i = ADDR_W'(77);
        rst_i = 1'b1;
        step();
        cam_wr_i = 1'b0;
        tests_run++;
        if (fb_wr_o !== 1'b0 || disp_bank_o !== 2'd0 || flip_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0 ||
            frame_ready_o !== 1'b0 || fb_rd_addr_o !== '0) begin
            tests_failed++;
            $display("FAIL midrst_state: got wr=%b disp=%0d flip=%0d drop=%0d rdy=%b rd=%h, expected all 0",
                     fb_wr_o, disp_bank_o, flip_cnt_o, drop_cnt_o, frame_ready_o, fb_rd_addr_o);
        end
        rst_i = 1'b0;
        vga_addr_i = '0;
        pulse_sof();
        cam_writes(2'd1, 2, 1'b0);
        step();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_write_gating();
        test_back_to_back();
        test_eof_flip_same_cycle();
        test_freeze();
        test_mid_reset();
        step();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL wr_missing: got %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
